// File: rtl/ahb_block_master.sv
// AHB-Lite block master: moves BLOCK_WORDS words per command between system
// memory and the AES core using pipelined NONSEQ/SEQ transfers.
module ahb_block_master #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned STRIDE      = 4
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned       CNT_W    = $clog2(BLOCK_WORDS) + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(STRIDE);
  localparam logic [1:0]        HT_IDLE  = 2'b00;
  localparam logic [1:0]        HT_NSEQ  = 2'b10;
  localparam logic [1:0]        HT_SEQ   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_PIPE,
    S_LAST,
    S_ABORT,
    S_FIN
  } state_t;

  state_t           state;
  logic             mode_q;
  logic [CNT_W-1:0] cnt;
  logic             final_addr;

  assign hsize = 3'($clog2(DATA_W / 8));

  always_comb final_addr = (cnt == LAST_IDX);

  // ADDR and PIPE share the address-acceptance path; PIPE additionally
  // completes the previous word's data phase on the same edge.
  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) begin
      state    <= S_IDLE;
      mode_q   <= 1'b0;
      cnt      <= '0;
      haddr    <= '0;
      htrans   <= HT_IDLE;
      hwrite   <= 1'b0;
      hwdata   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_pop   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      wr_pop   <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            haddr  <= mode ? waddr : raddr;
            htrans <= HT_NSEQ;
            hwrite <= mode;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_ADDR;
          end
        end
        S_ADDR, S_PIPE: begin
          if (state == S_PIPE && hresp) begin
            // error cancels the pending address immediately
            htrans <= HT_IDLE;
            hwrite <= 1'b0;
            if (hready) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              error <= 1'b1;
              state <= S_FIN;
            end else begin
              state <= S_ABORT;
            end
          end else if (hready) begin
            if (state == S_PIPE && !mode_q) begin
              rd_data  <= hrdata;
              rd_valid <= 1'b1;
            end
            cnt <= cnt + 1'b1;
            if (mode_q) begin
              hwdata <= wr_data;
              wr_pop <= 1'b1;
            end
            if (final_addr) begin
              htrans <= HT_IDLE;
              hwrite <= 1'b0;
              state  <= S_LAST;
            end else begin
              htrans <= HT_SEQ;
              haddr  <= haddr + STEP;
              state  <= S_PIPE;
            end
          end
        end
        S_LAST: begin
          if (hresp) begin
            if (hready) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              error <= 1'b1;
              state <= S_FIN;
            end else begin
              state <= S_ABORT;
            end
          end else if (hready) begin
            if (!mode_q) begin
              rd_data  <= hrdata;
              rd_valid <= 1'b1;
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FIN;
          end
        end
        S_ABORT: begin
          if (hready) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            error <= 1'b1;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_block_master.sv
// Directed bench for ahb_block_master: per-cycle vector tables for the block
// transfers, plus hand sequences for reset and ignored-start behaviour.
module tb_ahb_block_master;

  typedef struct {
    logic        hready;
    logic        hresp;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        wr_pop;
    logic        ck_wd;
    logic [31:0] hwdata;
    logic        busy;
    logic        done;
    logic        error;
  } vec_t;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic        hrst, start, mode, hready, hresp;
  logic [31:0] raddr, waddr, hrdata, wr_data;
  logic [1:0]  sel;

  logic [31:0] haddr_d[3], hwdata_d[3], rd_data_d[3];
  logic [1:0]  htrans_d[3];
  logic [2:0]  hsize_d[3];
  logic        hwrite_d[3], rd_valid_d[3], wr_pop_d[3], busy_d[3], done_d[3], error_d[3];
  logic        start_d[3];

  assign start_d[0] = start && (sel == 2'd0);
  assign start_d[1] = start && (sel == 2'd1);
  assign start_d[2] = start && (sel == 2'd2);

  ahb_block_master #(.DATA_W(32), .ADDR_W(32), .BLOCK_WORDS(4), .STRIDE(4)) dut4 (
    .hclk(tb_clk), .hrst(hrst), .start(start_d[0]), .mode(mode), .raddr(raddr), .waddr(waddr),
    .haddr(haddr_d[0]), .htrans(htrans_d[0]), .hwrite(hwrite_d[0]), .hsize(hsize_d[0]),
    .hwdata(hwdata_d[0]), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .rd_data(rd_data_d[0]), .rd_valid(rd_valid_d[0]), .wr_data(wr_data), .wr_pop(wr_pop_d[0]),
    .busy(busy_d[0]), .done(done_d[0]), .error(error_d[0]));

  ahb_block_master #(.DATA_W(32), .ADDR_W(32), .BLOCK_WORDS(1), .STRIDE(16)) dut1 (
    .hclk(tb_clk), .hrst(hrst), .start(start_d[1]), .mode(mode), .raddr(raddr), .waddr(waddr),
    .haddr(haddr_d[1]), .htrans(htrans_d[1]), .hwrite(hwrite_d[1]), .hsize(hsize_d[1]),
    .hwdata(hwdata_d[1]), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .rd_data(rd_data_d[1]), .rd_valid(rd_valid_d[1]), .wr_data(wr_data), .wr_pop(wr_pop_d[1]),
    .busy(busy_d[1]), .done(done_d[1]), .error(error_d[1]));

  ahb_block_master #(.DATA_W(32), .ADDR_W(32), .BLOCK_WORDS(8), .STRIDE(16)) dut8 (
    .hclk(tb_clk), .hrst(hrst), .start(start_d[2]), .mode(mode), .raddr(raddr), .waddr(waddr),
    .haddr(haddr_d[2]), .htrans(htrans_d[2]), .hwrite(hwrite_d[2]), .hsize(hsize_d[2]),
    .hwdata(hwdata_d[2]), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .rd_data(rd_data_d[2]), .rd_valid(rd_valid_d[2]), .wr_data(wr_data), .wr_pop(wr_pop_d[2]),
    .busy(busy_d[2]), .done(done_d[2]), .error(error_d[2]));

  logic [31:0] o_haddr, o_hwdata, o_rd_data;
  logic [1:0]  o_htrans;
  logic [2:0]  o_hsize;
  logic        o_hwrite, o_rd_valid, o_wr_pop, o_busy, o_done, o_error;

  assign o_haddr    = haddr_d[sel];
  assign o_hwdata   = hwdata_d[sel];
  assign o_rd_data  = rd_data_d[sel];
  assign o_htrans   = htrans_d[sel];
  assign o_hsize    = hsize_d[sel];
  assign o_hwrite   = hwrite_d[sel];
  assign o_rd_valid = rd_valid_d[sel];
  assign o_wr_pop   = wr_pop_d[sel];
  assign o_busy     = busy_d[sel];
  assign o_done     = done_d[sel];
  assign o_error    = error_d[sel];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd6:   return 32'habcd52c2;
      32'd10:  return 32'hf9c6f303;
      32'd14:  return 32'h030f8303;
      32'd18:  return 32'h1ab61040;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // slave: remembers the accepted address and returns its word in the data phase
  logic        dp_act = 1'b0;
  logic [31:0] dp_addr = '0;
  always @(posedge tb_clk) begin
    if (hready) begin
      dp_act  <= o_htrans[1];
      dp_addr <= o_haddr;
    end
  end
  assign hrdata = dp_act ? mem_word(dp_addr) : 32'h0BAD_0BAD;

  // core output buffer: head advances on each pop, next word presented during the pop
  logic [31:0] wq[4];
  int          pops = 0;
  int          widx;
  logic        wq_clr;
  always @(posedge tb_clk) begin
    if (wq_clr) pops <= 0;
    else if (o_wr_pop) pops <= pops + 1;
  end
  always_comb begin
    widx    = pops + (o_wr_pop ? 1 : 0);
    wr_data = (widx < 4) ? wq[widx] : 32'hEEEE_EEEE;
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vq[$];
  logic [31:0] a8[8];
  int   pops_seen;
  logic got_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge tb_clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rdy, input logic rsp, input logic [1:0] tr,
                              input logic [31:0] a, input logic wr, input logic rv,
                              input logic [31:0] rd, input logic pop, input logic ckw,
                              input logic [31:0] wd, input logic b, input logic d, input logic e);
    vec_t v;
    v.hready = rdy; v.hresp = rsp; v.htrans = tr; v.haddr = a; v.hwrite = wr;
    v.rd_valid = rv; v.rd_data = rd; v.wr_pop = pop; v.ck_wd = ckw; v.hwdata = wd;
    v.busy = b; v.done = d; v.error = e;
    return v;
  endfunction

  // issue start for one cycle; returns in cycle T+1
  task automatic kick(input logic [1:0] s, input logic m, input logic [31:0] ra, input logic [31:0] wa);
    sel = s; mode = m; raddr = ra; waddr = wa; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_vecs(input string tag);
    for (int j = 0; j < vq.size(); j++) begin
      hready = vq[j].hready;
      hresp  = vq[j].hresp;
      chk($sformatf("%s.c%0d.htrans", tag, j + 1), 32'(o_htrans), 32'(vq[j].htrans));
      if (vq[j].htrans != 2'b00)
        chk($sformatf("%s.c%0d.haddr", tag, j + 1), o_haddr, vq[j].haddr);
      chk($sformatf("%s.c%0d.hwrite", tag, j + 1), 32'(o_hwrite), 32'(vq[j].hwrite));
      chk($sformatf("%s.c%0d.rd_valid", tag, j + 1), 32'(o_rd_valid), 32'(vq[j].rd_valid));
      if (vq[j].rd_valid)
        chk($sformatf("%s.c%0d.rd_data", tag, j + 1), o_rd_data, vq[j].rd_data);
      chk($sformatf("%s.c%0d.wr_pop", tag, j + 1), 32'(o_wr_pop), 32'(vq[j].wr_pop));
      if (vq[j].ck_wd)
        chk($sformatf("%s.c%0d.hwdata", tag, j + 1), o_hwdata, vq[j].hwdata);
      chk($sformatf("%s.c%0d.busy", tag, j + 1), 32'(o_busy), 32'(vq[j].busy));
      chk($sformatf("%s.c%0d.done", tag, j + 1), 32'(o_done), 32'(vq[j].done));
      chk($sformatf("%s.c%0d.error", tag, j + 1), 32'(o_error), 32'(vq[j].error));
      cyc();
    end
    hready = 1'b1;
    hresp  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    hrst = 1'b0; start = 1'b0; mode = 1'b0; hready = 1'b1; hresp = 1'b0;
    raddr = '0; waddr = '0; sel = 2'd0; wq_clr = 1'b1;
    wq[0] = 32'h00112233; wq[1] = 32'h44556677; wq[2] = 32'h8899aabb; wq[3] = 32'hccddeeff;
    repeat (2) cyc();

    // reset values
    chk("rst.haddr", o_haddr, 32'h0);
    chk("rst.htrans", 32'(o_htrans), 32'h0);
    chk("rst.hwrite", 32'(o_hwrite), 32'h0);
    chk("rst.hwdata", o_hwdata, 32'h0);
    chk("rst.rd_data", o_rd_data, 32'h0);
    chk("rst.rd_valid", 32'(o_rd_valid), 32'h0);
    chk("rst.wr_pop", 32'(o_wr_pop), 32'h0);
    chk("rst.busy", 32'(o_busy), 32'h0);
    chk("rst.done", 32'(o_done), 32'h0);
    chk("rst.error", 32'(o_error), 32'h0);
    chk("rst.hsize", 32'(o_hsize), 32'd2);
    hrst = 1'b1; wq_clr = 1'b0;
    repeat (2) cyc();

    // zero-wait read, N=4
    vq = {};
    vq.push_back(mk(1, 0, 2'b10, 32'd6,  0, 0, 32'h0,         0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b11, 32'd10, 0, 0, 32'h0,         0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b11, 32'd14, 0, 1, 32'habcd52c2,  0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b11, 32'd18, 0, 1, 32'hf9c6f303,  0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b00, 32'd0,  0, 1, 32'h030f8303,  0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b00, 32'd0,  0, 1, 32'h1ab61040,  0, 0, 0, 0, 1, 0));
    vq.push_back(mk(1, 0, 2'b00, 32'd0,  0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    kick(2'd0, 1'b0, 32'd6, 32'd0);
    run_vecs("rd4");

    // zero-wait write, N=4
    wq_clr = 1'b1; cyc(); wq_clr = 1'b0;
    vq = {};
    vq.push_back(mk(1, 0, 2'b10, 32'd6000000,  1, 0, 0, 0, 0, 32'h0,         1, 0, 0));
    vq.push_back(mk(1, 0, 2'b11, 32'd6000004,  1, 0, 0, 1, 1, 32'h00112233,  1, 0, 0));
    vq.push_back(mk(1, 0, 2'b11, 32'd6000008,  1, 0, 0, 1, 1, 32'h44556677,  1, 0, 0));
    vq.push_back(mk(1, 0, 2'b11, 32'd6000012,  1, 0, 0, 1, 1, 32'h8899aabb,  1, 0, 0));
    vq.push_back(mk(1, 0, 2'b00, 32'd0,        0, 0, 0, 1, 1, 32'hccddeeff,  1, 0, 0));
    vq.push_back(mk(1, 0, 2'b00, 32'd0,        0, 0, 0, 0, 1, 32'hccddeeff,  0, 1, 0));
    vq.push_back(mk(1, 0, 2'b00, 32'd0,        0, 0, 0, 0, 1, 32'hccddeeff,  0, 0, 0));
    kick(2'd0, 1'b1, 32'd0, 32'd6000000);
    run_vecs("wr4");

    // wait states: 2 on word-1 address, 1 on word-3 data phase
    cyc();
    vq = {};
    vq.push_back(mk(1, 0, 2'b10, 32'd6,  0, 0, 32'h0,        0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 2'b11, 32'd10, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 2'b11, 32'd10, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b11, 32'd10, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b11, 32'd14, 0, 1, 32'habcd52c2, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b11, 32'd18, 0, 1, 32'hf9c6f303, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 2'b00, 32'd0,  0, 1, 32'h030f8303, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b00, 32'd0,  0, 0, 32'h0,        0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b00, 32'd0,  0, 1, 32'h1ab61040, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(1, 0, 2'b00, 32'd0,  0, 0, 32'h0,        0, 0, 0, 0, 0, 0));
    kick(2'd0, 1'b0, 32'd6, 32'd0);
    run_vecs("wait");

    // ERROR response on word-2 data phase
    cyc();
    vq = {};
    vq.push_back(mk(1, 0, 2'b10, 32'd6,  0, 0, 32'h0,        0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b11, 32'd10, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b11, 32'd14, 0, 1, 32'habcd52c2, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 2'b11, 32'd18, 0, 1, 32'hf9c6f303, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 1, 2'b00, 32'd0,  0, 0, 32'h0,        0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b00, 32'd0,  0, 0, 32'h0,        0, 0, 0, 0, 1, 1));
    vq.push_back(mk(1, 0, 2'b00, 32'd0,  0, 0, 32'h0,        0, 0, 0, 0, 0, 0));
    kick(2'd0, 1'b0, 32'd6, 32'd0);
    run_vecs("err");

    // BLOCK_WORDS=1, STRIDE=16, base near top of address space
    cyc();
    vq = {};
    vq.push_back(mk(1, 0, 2'b10, 32'hFFFFFFF0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b00, 32'h0,        0, 0, 32'h0,        0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 2'b00, 32'h0,        0, 1, 32'h5A5AFFF0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(1, 0, 2'b00, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 0));
    kick(2'd1, 1'b0, 32'hFFFFFFF0, 32'd0);
    run_vecs("n1");

    // BLOCK_WORDS=8, STRIDE=16: address wraps to 0 on word 1
    cyc();
    a8[0] = 32'hFFFFFFF0; a8[1] = 32'h00; a8[2] = 32'h10; a8[3] = 32'h20;
    a8[4] = 32'h30;       a8[5] = 32'h40; a8[6] = 32'h50; a8[7] = 32'h60;
    vq = {};
    for (int j = 1; j <= 11; j++) begin
      vec_t v;
      v = mk(1, 0, 2'b00, 32'h0, 0, 0, 32'h0, 0, 0, 0, (j <= 9) ? 1'b1 : 1'b0, (j == 10) ? 1'b1 : 1'b0, 0);
      if (j == 1) v.htrans = 2'b10;
      else if (j <= 8) v.htrans = 2'b11;
      if (j <= 8) v.haddr = a8[j - 1];
      if (j >= 3 && j <= 10) begin
        v.rd_valid = 1'b1;
        v.rd_data  = mem_word(a8[j - 3]);
      end
      vq.push_back(v);
    end
    kick(2'd2, 1'b0, 32'hFFFFFFF0, 32'd0);
    run_vecs("n8");

    // reset during a write; start while busy is ignored
    cyc();
    wq_clr = 1'b1; cyc(); wq_clr = 1'b0;
    kick(2'd0, 1'b1, 32'd0, 32'd6000000);
    cyc();
    sel = 2'd0; start = 1'b1; mode = 1'b0; raddr = 32'h100;
    cyc();
    start = 1'b0;
    chk("busy_start.htrans", 32'(o_htrans), 32'(2'b11));
    chk("busy_start.haddr", o_haddr, 32'd6000008);
    chk("busy_start.hwrite", 32'(o_hwrite), 32'd1);
    #2 hrst = 1'b0;
    #1;
    chk("midrst.haddr", o_haddr, 32'h0);
    chk("midrst.htrans", 32'(o_htrans), 32'h0);
    chk("midrst.hwrite", 32'(o_hwrite), 32'h0);
    chk("midrst.hwdata", o_hwdata, 32'h0);
    chk("midrst.wr_pop", 32'(o_wr_pop), 32'h0);
    chk("midrst.rd_data", o_rd_data, 32'h0);
    chk("midrst.busy", 32'(o_busy), 32'h0);
    wq_clr = 1'b1;
    cyc();
    wq_clr = 1'b0;
    chk("midrst.done", 32'(o_done), 32'h0);
    hrst = 1'b1;
    kick(2'd0, 1'b1, 32'd0, 32'd6000000);
    chk("restart.htrans", 32'(o_htrans), 32'(2'b10));
    chk("restart.haddr", o_haddr, 32'd6000000);
    chk("restart.busy", 32'(o_busy), 32'd1);
    pops_seen = 0;
    got_done  = 1'b0;
    for (int k = 0; k < 20 && !got_done; k++) begin
      cyc();
      if (o_wr_pop) pops_seen++;
      if (o_done) got_done = 1'b1;
    end
    chk("restart.done_seen", 32'(got_done), 32'd1);
    chk("restart.pops", 32'(pops_seen), 32'd4);
    chk("restart.hwdata", o_hwdata, 32'hccddeeff);
    chk("restart.error", 32'(o_error), 32'd0);

    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_block_master.md
# ahb_block_master

Parametrised AHB-Lite bus master that moves one N-word block between system memory and the AES core per command, replacing the fixed single-word master. It issues pipelined NONSEQ/SEQ transfers with overlapped address and data phases, honours slave wait states, and aborts cleanly on an ERROR response. Read mode streams fetched words to the core; write mode pops result words from the core's output buffer.

## Interface
Parameters:
- DATA_W, 32, AHB data width, word size.
- ADDR_W, 32, AHB address width.
- BLOCK_WORDS, 4, words per command, 1..256.
- STRIDE, 4, byte increment between word addresses.

Ports:
- hclk  in  1  system clock, rising edge.
- hrst  in  1  asynchronous active-low reset.
- start  in  1  command strobe, sampled only in IDLE.
- mode  in  1  0 = read block, 1 = write block.
- raddr  in  ADDR_W  read base address.
- waddr  in  ADDR_W  write base address.
- haddr  out  ADDR_W  AHB address.
- htrans  out  2  00 IDLE, 10 NONSEQ, 11 SEQ.
- hwrite  out  1  AHB direction.
- hsize  out  3  constant log2(DATA_W/8).
- hwdata  out  DATA_W  AHB write data.
- hrdata  in  DATA_W  AHB read data.
- hready  in  1  slave ready.
- hresp  in  1  0 OKAY, 1 ERROR.
- rd_data  out  DATA_W  fetched word to core.
- rd_valid  out  1  one-cycle strobe per fetched word.
- wr_data  in  DATA_W  word from core output buffer, head of queue.
- wr_pop  out  1  one-cycle pop of wr_data.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle pulse with done on aborted transfer.

## Operation
- States: IDLE, ADDR (address phase, no data phase pending), PIPE (address i + data i-1), LAST (data phase of final word only), ABORT (second cycle of error response), FIN.
- IDLE: start=1 latches mode and base (raddr if mode=0, waddr if mode=1). Next state ADDR. start in any other state ignored.
- Word i address = base + i*STRIDE, modulo 2^ADDR_W; wrap is permitted, no 1 KB boundary check.
- htrans NONSEQ for word 0, SEQ for words 1..N-1, IDLE otherwise. hwrite = latched mode while htrans active, else 0.
- Address phase holds haddr/htrans/hwrite unchanged while hready=0.
- Address accepted (hready=1 with htrans active): counter increments. ADDR→PIPE if more words remain, ADDR→LAST if it was the final one; PIPE→LAST on acceptance of the final address.
- Read: at a data-phase edge with hready=1 and hresp=0, rd_data <= hrdata and rd_valid=1 for the next cycle. Words delivered in address order.
- Write: at each address-acceptance edge, hwdata <= wr_data and wr_pop=1 for the cycle following; hwdata held until its data phase completes.
- LAST: hready=1 and hresp=0 → FIN. FIN: done=1 for one cycle → IDLE.
- Error: hresp=1 with hready=0 in a data phase → htrans forced IDLE next cycle (pending address cancelled, no further wr_pop/rd_valid) → ABORT; at hresp=1,hready=1 → FIN with error=1 alongside done. The erroring word produces no rd_valid.
- BLOCK_WORDS=1: ADDR→LAST directly, never SEQ.

## Timing
- Reset (hrst=0, immediate): state IDLE; haddr=0, htrans=00, hwrite=0, hwdata=0, rd_data=0, rd_valid=0, wr_pop=0, busy=0, done=0, error=0; hsize is constant. Reset mid-transfer abandons the block; no done pulse.
- start at edge T → NONSEQ on bus cycle T+1.
- Zero-wait latency: N words complete in N+1 bus cycles after start; done at cycle T+N+2.
- rd_valid lags the corresponding data-phase completion by exactly one cycle; consecutive words back-to-back at zero wait.
- busy=1 from cycle T+1 through LAST/ABORT; low in FIN (done) and IDLE.
- A new start is accepted in the cycle done is high only after returning to IDLE, i.e. not before cycle T+N+3.

## Test plan
- Read, BLOCK_WORDS=4, raddr=6, hready=1 constant, memory 0xabcd52c2,0xf9c6f303,0x030f8303,0x1ab61040 → haddr 6,10,14,18; htrans 10,11,11,11,00; rd_data in that order on 4 consecutive rd_valid; done at start+6.
- Write, waddr=6000000, wr_data queue 0x00112233,0x44556677,0x8899aabb,0xccddeeff → haddr 6000000..6000012 step 4, hwrite=1, 4 wr_pop pulses, hwdata matches each data phase.
- Wait states: hready low 2 cycles on word 1 address and 1 cycle on word 3 data phase → haddr/htrans/hwdata held stable, no duplicate rd_valid/wr_pop, done at start+9.
- Error on word 2 read data phase (hresp=1,hready=0 then hresp=1,hready=1) → rd_valid only for words 0,1, htrans=00 the cycle after first error cycle, done and error both pulse once.
- hrst low at word 2 of a write → all outputs zero immediately; start accepted next cycle after release; start pulsed while busy ignored.
- BLOCK_WORDS=1 and BLOCK_WORDS=8 with STRIDE=16, raddr=0xFFFFFFF0 → single NONSEQ for N=1; for N=8 address wraps to 0x00000000 on word 1.
